// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct constants, loader descriptor kinds and the descriptor payload,
// shared by the instruction encoder and decoder.
package mips_isa_pkg;

    localparam int unsigned KIND_W = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned TGT_W  = 26;
    localparam int unsigned WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [KIND_W-1:0] KIND_ADD  = 4'd0;
    localparam logic [KIND_W-1:0] KIND_SUB  = 4'd1;
    localparam logic [KIND_W-1:0] KIND_AND  = 4'd2;
    localparam logic [KIND_W-1:0] KIND_OR   = 4'd3;
    localparam logic [KIND_W-1:0] KIND_SLT  = 4'd4;
    localparam logic [KIND_W-1:0] KIND_LW   = 4'd5;
    localparam logic [KIND_W-1:0] KIND_SW   = 4'd6;
    localparam logic [KIND_W-1:0] KIND_BEQ  = 4'd7;
    localparam logic [KIND_W-1:0] KIND_ADDI = 4'd8;
    localparam logic [KIND_W-1:0] KIND_J    = 4'd9;

    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [IMM_W-1:0]  imm;
        logic [TGT_W-1:0]  target;
    } instr_desc_t;

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: mnemonic-level descriptor to 32-bit MIPS word plus legality flag.
module instr_encode
    import mips_isa_pkg::*;
(
    input  instr_desc_t       desc_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              legal_c_o
);

    always_comb begin
        word_c_o  = '0;
        legal_c_o = 1'b1;
        case (desc_i.kind)
            KIND_ADD:  word_c_o = {OP_RTYPE, desc_i.rs, desc_i.rt, desc_i.rd, 5'd0, FN_ADD};
            KIND_SUB:  word_c_o = {OP_RTYPE, desc_i.rs, desc_i.rt, desc_i.rd, 5'd0, FN_SUB};
            KIND_AND:  word_c_o = {OP_RTYPE, desc_i.rs, desc_i.rt, desc_i.rd, 5'd0, FN_AND};
            KIND_OR:   word_c_o = {OP_RTYPE, desc_i.rs, desc_i.rt, desc_i.rd, 5'd0, FN_OR};
            KIND_SLT:  word_c_o = {OP_RTYPE, desc_i.rs, desc_i.rt, desc_i.rd, 5'd0, FN_SLT};
            KIND_LW:   word_c_o = {OP_LW,   desc_i.rs, desc_i.rt, desc_i.imm};
            KIND_SW:   word_c_o = {OP_SW,   desc_i.rs, desc_i.rt, desc_i.imm};
            KIND_BEQ:  word_c_o = {OP_BEQ,  desc_i.rs, desc_i.rt, desc_i.imm};
            KIND_ADDI: word_c_o = {OP_ADDI, desc_i.rs, desc_i.rt, desc_i.imm};
            KIND_J:    word_c_o = {OP_J, desc_i.target};
            default:   legal_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction descriptors, encodes them and writes them
// sequentially into instruction memory, one word per WRITE cycle.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KIND_W-1:0] in_kind,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [TGT_W-1:0]  in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    instr_desc_t         desc_c;
    logic [WORD_W-1:0]   enc_word_c;
    logic                enc_legal_c;
    logic                full_c;

    assign desc_c.kind   = in_kind;
    assign desc_c.rs     = in_rs;
    assign desc_c.rt     = in_rt;
    assign desc_c.rd     = in_rd;
    assign desc_c.imm    = in_imm;
    assign desc_c.target = in_target;

    instr_encode u_encode (
        .desc_i    (desc_c),
        .word_c_o  (enc_word_c),
        .legal_c_o (enc_legal_c)
    );

    // The word being written in WRITE fills the session to DEPTH.
    assign full_c = (count_q + CNT_W'(1)) == CNT_W'(DEPTH);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid && ready_q) begin
                    if (enc_legal_c) begin
                        word_d  = enc_word_c;
                        last_d  = in_last;
                        state_d = S_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + CNT_W'(1);
                if (last_q) begin
                    state_d = S_DONE;
                end else if (full_c) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so they register in step with it.
        we_d    = (state_d == S_WRITE);
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= ADDR_W'(BASE_ADDR);
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            err_q   <= err_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: scoreboard of expected memory writes,
// one default instance and one with DEPTH=4 sharing the descriptor stream.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [3:0]  in_kind = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;

    logic        rdy_a, we_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, we_b, busy_b, done_b, err_b;
    logic [7:0]  addr_b;
    logic [31:0] wdata_b;
    logic [8:0]  cnt_b;

    int errors = 0;
    int checks = 0;
    int sel = 0;
    logic [7:0] exp_addr = 8'd0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t q_a[$];
    wr_t q_b[$];
    wr_t pop_a, pop_b;
    logic hs_prev_a = 1'b0, hs_prev_b = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_loader u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .busy(busy_a), .done(done_a), .err(err_a), .count(cnt_a)
    );

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .busy(busy_b), .done(done_b), .err(err_b), .count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                                        input logic [15:0] imm, input logic [25:0] tgt);
        case (k)
            4'd0: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4: return {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5: return {6'b100011, rs, rt, imm};
            4'd6: return {6'b101011, rs, rt, imm};
            4'd7: return {6'b000100, rs, rt, imm};
            4'd8: return {6'b001000, rs, rt, imm};
            4'd9: return {6'b000010, tgt};
            default: return 32'h0;
        endcase
    endfunction

    // Write monitors: every strobe must follow a legal handshake by one cycle and match the scoreboard.
    always @(negedge clk) begin
        chk("we_latency_a", 32'(we_a), 32'(hs_prev_a));
        if (we_a) begin
            if (q_a.size() == 0) chk("spurious_write_a", 32'd1, 32'd0);
            else begin
                pop_a = q_a.pop_front();
                chk("addr_a", 32'(addr_a), 32'(pop_a.addr));
                chk("data_a", wdata_a, pop_a.data);
            end
        end
        hs_prev_a <= in_valid && rdy_a && (in_kind <= 4'd9) && rst_n;
    end

    always @(negedge clk) begin
        chk("we_latency_b", 32'(we_b), 32'(hs_prev_b));
        if (we_b) begin
            if (q_b.size() == 0) chk("spurious_write_b", 32'd1, 32'd0);
            else begin
                pop_b = q_b.pop_front();
                chk("addr_b", 32'(addr_b), 32'(pop_b.addr));
                chk("data_b", wdata_b, pop_b.data);
            end
        end
        hs_prev_b <= in_valid && rdy_b && (in_kind <= 4'd9) && rst_n;
    end

    task automatic do_start();
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        exp_addr = 8'd0;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last, input bit rnd, input bit rst_after);
        bit got = 0;
        wr_t w;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last;
        for (int i = 0; i < 60 && !got; i++) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && ((sel != 0) ? rdy_b : rdy_a)) begin
                got = 1;
                if (k <= 4'd9) begin
                    w.addr = exp_addr;
                    w.data = enc(k, rs, rt, rd, imm, tgt);
                    exp_addr++;
                    if (sel != 0) q_b.push_back(w); else q_a.push_back(w);
                end
            end
            @(posedge clk); #1;
            if (got && rst_after) rst_n = 1'b0;
        end
        in_valid = 1'b0;
        if (!got) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int exp_cnt, input bit exp_err);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((sel != 0) ? done_b : done_a) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("count_at_done", (sel != 0) ? 32'(cnt_b) : 32'(cnt_a), 32'(exp_cnt));
        chk("err_at_done", (sel != 0) ? 32'(err_b) : 32'(err_a), 32'(exp_err));
        @(negedge clk);
        chk("done_one_cycle", (sel != 0) ? 32'(done_b) : 32'(done_a), 32'd0);
        chk("busy_after_done", (sel != 0) ? 32'(busy_b) : 32'(busy_a), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_wdata", wdata_a, 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        @(posedge clk); #1;

        // Single ADD, then encoding sweep streamed back-to-back.
        sel = 0;
        do_start();
        chk("ready_after_start", 32'(rdy_a), 32'd1);
        chk("busy_after_start", 32'(busy_a), 32'd1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 1'b0, 1'b0);
        wait_done(1, 1'b0);
        chk("add_word_held", wdata_a, 32'h00221820);

        do_start();
        send(4'd5, 5'd29, 5'd8, 5'd0, 16'd4, 26'd0, 1'b0, 1'b0, 1'b0);
        send(4'd6, 5'd29, 5'd9, 5'd0, 16'd8, 26'd0, 1'b0, 1'b0, 1'b0);
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0, 1'b0, 1'b0);
        send(4'd8, 5'd0, 5'd5, 5'd31, 16'd7, 26'd0, 1'b0, 1'b0, 1'b0);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000010, 1'b1, 1'b0, 1'b0);
        wait_done(5, 1'b0);
        chk("j_word_held", wdata_a, 32'h08000010);

        do_start();
        send(4'd2, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 1'b0, 1'b1, 1'b0);
        send(4'd3, 5'd10, 5'd11, 5'd12, 16'd0, 26'd0, 1'b0, 1'b1, 1'b0);
        send(4'd4, 5'd13, 5'd14, 5'd15, 16'd0, 26'd0, 1'b0, 1'b1, 1'b0);
        send(4'd1, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 1'b1, 1'b1, 1'b0);
        wait_done(4, 1'b0);
        chk("sub_word_held", wdata_a, 32'h00222022);

        // Illegal kind after two legal words.
        do_start();
        send(4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0);
        send(4'd8, 5'd1, 5'd1, 5'd0, 16'h8000, 26'd0, 1'b0, 1'b0, 1'b0);
        send(4'd12, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1, 1'b0, 1'b0, 1'b0);
        wait_done(2, 1'b1);
        chk("err_sticky_idle", 32'(err_a), 32'd1);
        do_start();
        @(negedge clk);
        chk("err_cleared_by_start", 32'(err_a), 32'd0);
        @(posedge clk); #1;
        send(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1, 1'b0, 1'b0);
        wait_done(1, 1'b0);

        // Overflow on the DEPTH=4 instance.
        sel = 1;
        do_start();
        for (int i = 0; i < 4; i++)
            send(4'd8, 5'd0, 5'(i), 5'd0, 16'(i + 100), 26'd0, 1'b0, 1'b0, 1'b0);
        wait_done(4, 1'b1);
        in_kind = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("ready_low_after_overflow", 32'(rdy_b), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("err_b_sticky", 32'(err_b), 32'd1);

        // Exact fill with last on the DEPTH-th word keeps err clear.
        do_start();
        for (int i = 0; i < 4; i++)
            send(4'd1, 5'(i), 5'd3, 5'd2, 16'd0, 26'd0, 1'(i == 3), 1'b0, 1'b0);
        wait_done(4, 1'b0);

        // Reset during WRITE of the second word.
        sel = 0;
        do_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0);
        send(4'd1, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_we", 32'(we_a), 32'd0);
        chk("midrst_addr", 32'(addr_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_ready", 32'(rdy_a), 32'd0);
        chk("midrst_count", 32'(cnt_a), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ignores_valid", 32'(rdy_a), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        do_start();
        send(4'd4, 5'd9, 5'd10, 5'd11, 16'd0, 26'd0, 1'b1, 1'b0, 1'b0);
        wait_done(1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_a_empty", 32'(q_a.size()), 32'd0);
        chk("scoreboard_b_empty", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the instruction decoder: takes mnemonic-level instruction descriptors over a valid/ready stream.
- Encodes each into a 32-bit MIPS word (R-format add/sub/and/or/slt, lw, sw, beq, addi, j) and writes it sequentially into instruction memory.
- Sits between the test/boot host and the instruction memory; used to load programs before the core runs.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 256, maximum words per load; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a load session; honoured only in IDLE.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10–15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate for LW/SW/BEQ/ADDI.
- in_target  in  26  jump target for J.
- in_last  in  1  final descriptor of the session.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky error flag; cleared by start.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, in_ready=0, busy=0, done=0, err=0, count=0. Reset mid-session abandons it; no further writes.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: start=1 → LOAD; addr=BASE_ADDR, count=0, err=0.
- LOAD: in_ready=1. On handshake:
  - Legal kind: latch encoded word and in_last; → WRITE.
  - Illegal kind: err=1, no write; → DONE.
- WRITE (exactly one cycle, in_ready=0): imem_we=1, imem_addr=current addr, imem_wdata=latched word. At the edge: addr+1, count+1.
  - Latched last=1, or count+1 == DEPTH → DONE.
  - Otherwise → LOAD.
  - Latency: handshake cycle N → write strobe in cycle N+1; maximum throughput one word per 2 cycles.
- Overflow: a session reaching DEPTH words without last → DONE with err=1; the DEPTH-th word is still written. With last on that same word, err stays 0.
- DONE: done=1 for one cycle → IDLE. err holds until the next start.
- start outside IDLE is ignored. in_valid outside LOAD is ignored; no data is lost because in_ready=0.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}; funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type: {op, rs, rt, imm}; op LW 100011, SW 101011, BEQ 000100, ADDI 001000. rd is ignored.
  - J: {6'b000010, target}.
- imem_wdata is registered and holds its last value when imem_we=0.

Decomposition:
- Shared package mips_isa_pkg:
  - opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI/OP_J;
  - funct constants FN_ADD/FN_SUB/FN_AND/FN_OR/FN_SLT;
  - in_kind encoding constants KIND_*.
- The decoder reuses the same opcode/funct constants.
- One combinational sub-module, instr_encode (kind + fields → word + legal flag). The FSM, address counter and output registers stay in the top.

Test Plan:
- Reset then start; send ADD rs=1 rt=2 rd=3, last=1 → one write: addr 0, data 0x00221820; done pulse; count=1; err=0.
- Stream without stalls: LW rs=29 rt=8 imm=4; SW rs=29 rt=9 imm=8; BEQ rs=1 rt=2 imm=0xFFFF; ADDI rs=0 rt=5 imm=7; J target=0x0000010 (last) → data 0x8FA80004, 0xAFA90008, 0x1022FFFF, 0x20050007, 0x08000010 at addrs 0–4, each one cycle after its handshake; count=5.
- in_valid toggled randomly; SUB rs=1 rt=2 rd=4 → single write 0x00222022; no duplicate or dropped writes.
- Descriptor with kind=12 after two legal words → no write for it; err=1; done pulse; err clears on the next start.
- DEPTH=4, six descriptors without last → exactly 4 writes (addrs 0–3); err=1; in_ready low after the 4th.
- rst_n low during WRITE of the second word → imem_we=0 the next cycle; addr=BASE_ADDR; state IDLE; start-only response afterwards.
